// File: rtl/zf_pkg.sv
// Shared ZF-detector definitions: Q4.12 word width, norm2_sched state encoding
// and the column slicing of the 2x2 complex channel matrix H.
package zf_pkg;

  localparam int unsigned W = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SEND0 = 3'd1;
  localparam logic [2:0] ST_WAIT0 = 3'd2;
  localparam logic [2:0] ST_SEND1 = 3'd3;
  localparam logic [2:0] ST_WAIT1 = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  // Column 0 occupies the upper half of H, column 1 the lower half.
  localparam int unsigned COL0_LSB = 4 * W;
  localparam int unsigned COL1_LSB = 0;

  function automatic logic [4*W-1:0] h_col(input logic [8*W-1:0] h, input logic sel);
    return sel ? h[COL1_LSB +: 4*W] : h[COL0_LSB +: 4*W];
  endfunction

endpackage

// File: rtl/norm2_sched_tmo.sv
// Reloadable handshake timeout counter: cleared on state entry, counts while
// run is high and saturates with expired asserted at TIMEOUT-1.
module norm2_sched_tmo #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear)
      cnt <= '0;
    else if (run && !expired)
      cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/norm2_sched.sv
// Schedules both H columns through one shared norm2 unit and returns the pair
// of column norms. Optional min-norm index: define NORM2_SCHED_MIN_EN.
module norm2_sched
  import zf_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [8*W-1:0] h_in,
  output logic [4*W-1:0] n_vector,
  output logic           n_enable,
  output logic           n_accept_in,
  input  logic           n_accept_out,
  input  logic           n_ready_out,
  input  logic [W-1:0]   n_res,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   norm0,
  output logic [W-1:0]   norm1,
  output logic           err,
  output logic           min_idx
);

  logic [2:0]     state;
  logic [2:0]     state_next;
  logic [4*W-1:0] col1;
  logic           timeout;
  logic           tmo_clear;
  logic           tmo_run;
  logic           expired;

  always_comb begin
    state_next = state;
    timeout    = 1'b0;
    case (state)
      ST_IDLE:  if (in_valid) state_next = ST_SEND0;
      ST_SEND0: if (n_accept_out) state_next = ST_WAIT0; else timeout = expired;
      ST_WAIT0: if (n_ready_out)  state_next = ST_SEND1; else timeout = expired;
      ST_SEND1: if (n_accept_out) state_next = ST_WAIT1; else timeout = expired;
      ST_WAIT1: if (n_ready_out)  state_next = ST_DONE;  else timeout = expired;
      ST_DONE:  if (out_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (timeout) state_next = ST_DONE;
  end

  assign tmo_run   = (state == ST_SEND0) || (state == ST_WAIT0) ||
                     (state == ST_SEND1) || (state == ST_WAIT1);
  assign tmo_clear = (state_next != state);

  norm2_sched_tmo #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmo_clear),
    .run    (tmo_run),
    .expired(expired)
  );

  // Handshake outputs are registered alongside the state so each one is set
  // on the edge that enters the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      n_enable    <= 1'b0;
      n_accept_in <= 1'b0;
      n_vector    <= '0;
      col1        <= '0;
      norm0       <= '0;
      norm1       <= '0;
      err         <= 1'b0;
    end else begin
      state <= state_next;
      if (timeout) begin
        n_enable    <= 1'b0;
        n_accept_in <= 1'b0;
        out_valid   <= 1'b1;
        err         <= 1'b1;
        norm1       <= '1;
        if (state == ST_SEND0 || state == ST_WAIT0)
          norm0 <= '1;
      end else begin
        case (state)
          ST_IDLE: if (in_valid) begin
            in_ready <= 1'b0;
            err      <= 1'b0;
            n_enable <= 1'b1;
            n_vector <= h_col(h_in, 1'b0);
            col1     <= h_col(h_in, 1'b1);
          end
          ST_SEND0, ST_SEND1: if (n_accept_out) begin
            n_enable    <= 1'b0;
            n_accept_in <= 1'b1;
          end
          ST_WAIT0: if (n_ready_out) begin
            norm0       <= n_res;
            n_accept_in <= 1'b0;
            n_enable    <= 1'b1;
            n_vector    <= col1;
          end
          ST_WAIT1: if (n_ready_out) begin
            norm1       <= n_res;
            n_accept_in <= 1'b0;
            out_valid   <= 1'b1;
          end
          ST_DONE: if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef NORM2_SCHED_MIN_EN
  always_ff @(posedge clk) begin
    if (reset)
      min_idx <= 1'b0;
    else if (state == ST_WAIT1 && n_ready_out)
      min_idx <= (n_res < norm0);
    else if (timeout || (state == ST_IDLE && in_valid))
      min_idx <= 1'b0;
  end
`else
  assign min_idx = 1'b0;
`endif

endmodule
